// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - EX/MEM boundary bundle for the memory stage (MEM_STALL_CNT_EN adds StallCntM)
interface memory_stage_if;
    logic        RegWriteE;
    logic        MemWriteE;
    logic [1:0]  MemtoRegE;
    logic        jumpE;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUMultOut;
    logic [31:0] WriteDataE;
    logic [31:0] PCPlus4E;

    logic        RegWriteM;
    logic [1:0]  MemtoRegM;
    logic        jumpM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM;
    logic [31:0] ReadDataM;
    logic [31:0] PCPlus4M;
    logic        MemBusyM;
`ifdef MEM_STALL_CNT_EN
    logic [31:0] StallCntM;
`endif

    modport master (
`ifdef MEM_STALL_CNT_EN
        input  StallCntM,
`endif
        output RegWriteE, MemWriteE, MemtoRegE, jumpE, WriteRegE,
        output ALUMultOut, WriteDataE, PCPlus4E,
        input  RegWriteM, MemtoRegM, jumpM, WriteRegM,
        input  ALUOutM, ReadDataM, PCPlus4M, MemBusyM
    );

    modport slave (
`ifdef MEM_STALL_CNT_EN
        output StallCntM,
`endif
        input  RegWriteE, MemWriteE, MemtoRegE, jumpE, WriteRegE,
        input  ALUMultOut, WriteDataE, PCPlus4E,
        output RegWriteM, MemtoRegM, jumpM, WriteRegM,
        output ALUOutM, ReadDataM, PCPlus4M, MemBusyM
    );
endinterface

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS MEM stage: EX/MEM register, latency-configurable data memory, stall request (MEM_STALL_CNT_EN adds stall counter)
module memory_stage #(
    parameter int MEM_WORDS   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    memory_stage_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic          r_reg_write;
    logic          r_mem_write;
    logic [1:0]    r_memto_reg;
    logic          r_jump;
    logic [4:0]    r_write_reg;
    logic [31:0]   r_alu_out;
    logic [31:0]   r_write_data;
    logic [31:0]   r_pc_plus4;
    logic [31:0]   r_mem [MEM_WORDS];

    logic          w_busy;
    logic          w_memop_e;
    logic [1:0]    w_memto_reg_e;
    logic [AW-1:0] w_index;

    // Reserved select 11 is folded to 00 so it never counts as a memory op downstream.
    assign w_memto_reg_e = (bus.MemtoRegE == 2'b11) ? 2'b00 : bus.MemtoRegE;
    assign w_memop_e     = bus.MemWriteE | (w_memto_reg_e == 2'b01);
    assign w_busy        = (r_state == S_WAIT);
    // Byte offset dropped; address bits above the array depth alias.
    assign w_index       = r_alu_out[AW+1:2];

    // Next-state: an incoming memop starts the wait countdown; WAIT ends when the count runs out.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_memop_e && (MEM_LATENCY > 0)) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CW'(MEM_LATENCY);
                end
            end
            S_WAIT: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // EX/MEM register: captures only when not stalled, otherwise holds the op in M.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_memto_reg  <= 2'b00;
            r_jump       <= 1'b0;
            r_write_reg  <= 5'd0;
            r_alu_out    <= 32'd0;
            r_write_data <= 32'd0;
            r_pc_plus4   <= 32'd0;
        end else if (!w_busy) begin
            r_reg_write  <= bus.RegWriteE;
            r_mem_write  <= bus.MemWriteE;
            r_memto_reg  <= w_memto_reg_e;
            r_jump       <= bus.jumpE;
            r_write_reg  <= bus.WriteRegE;
            r_alu_out    <= bus.ALUMultOut;
            r_write_data <= bus.WriteDataE;
            r_pc_plus4   <= bus.PCPlus4E;
        end
    end

    // Store commits once, on the edge that ends the op's final (non-busy) M cycle.
    always_ff @(posedge clk) begin
        if (!rst && r_mem_write && !w_busy) begin
            r_mem[w_index] <= r_write_data;
        end
    end

    assign bus.RegWriteM = r_reg_write;
    assign bus.MemtoRegM = r_memto_reg;
    assign bus.jumpM     = r_jump;
    assign bus.WriteRegM = r_write_reg;
    assign bus.ALUOutM   = r_alu_out;
    assign bus.PCPlus4M  = r_pc_plus4;
    assign bus.ReadDataM = r_mem[w_index];
    assign bus.MemBusyM  = w_busy;

`ifdef MEM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_busy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.StallCntM = r_stall_cnt;
`endif
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage
module tb_memory_stage;
    localparam int LAT   = 2;
    localparam int WORDS = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_stage_if if0 ();
    memory_stage_if if1 ();

    memory_stage #(.MEM_WORDS(WORDS), .MEM_LATENCY(LAT)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    memory_stage #(.MEM_WORDS(WORDS), .MEM_LATENCY(0))   dut1 (.clk(clk), .rst(rst), .bus(if1));

    int checks = 0;
    int errors = 0;
    logic [31:0] model [WORDS];
    int stall_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic rw, input logic mw, input logic [1:0] mtr, input logic jmp,
                          input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] pc4);
        if0.RegWriteE  = rw;
        if0.MemWriteE  = mw;
        if0.MemtoRegE  = mtr;
        if0.jumpE      = jmp;
        if0.WriteRegE  = wr;
        if0.ALUMultOut = alu;
        if0.WriteDataE = wd;
        if0.PCPlus4E   = pc4;
    endtask

    // Issues one op from a negedge and follows it until its last M cycle (returns at that negedge).
    task automatic do_op0(input logic rw, input logic mw, input logic [1:0] mtr, input logic jmp,
                          input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] pc4);
        logic       memop;
        logic [1:0] exp_mtr;
        int         idx;
        int         nbusy;
        exp_mtr = (mtr == 2'b11) ? 2'b00 : mtr;
        memop   = mw | (exp_mtr == 2'b01);
        idx     = int'((alu >> 2) % WORDS);
        drive0(rw, mw, mtr, jmp, wr, alu, wd, pc4);
        @(posedge clk); @(negedge clk);
        chk("RegWriteM", {31'd0, if0.RegWriteM}, {31'd0, rw});
        chk("MemtoRegM", {30'd0, if0.MemtoRegM}, {30'd0, exp_mtr});
        chk("jumpM",     {31'd0, if0.jumpM}, {31'd0, jmp});
        chk("WriteRegM", {27'd0, if0.WriteRegM}, {27'd0, wr});
        chk("ALUOutM",   if0.ALUOutM, alu);
        chk("PCPlus4M",  if0.PCPlus4M, pc4);
        chk("busy_first", {31'd0, if0.MemBusyM}, {31'd0, memop});
        nbusy = 0;
        while (if0.MemBusyM === 1'b1 && nbusy < 20) begin
            nbusy++;
            drive0(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom),
                   $urandom, $urandom, $urandom);
            @(posedge clk); @(negedge clk);
            chk("hold_ALUOutM",   if0.ALUOutM, alu);
            chk("hold_WriteRegM", {27'd0, if0.WriteRegM}, {27'd0, wr});
        end
        chk("busy_cycles", nbusy, memop ? LAT : 0);
        if (exp_mtr == 2'b01) chk("load_data", if0.ReadDataM, model[idx]);
        if (mw) model[idx] = wd;
        if (memop) stall_exp += LAT;
`ifdef MEM_STALL_CNT_EN
        chk("StallCntM", if0.StallCntM, 32'(stall_exp));
`endif
    endtask

    initial begin
        int          idx;
        int          kind;
        logic [31:0] alu;
        logic [1:0]  mtr;
        logic        mw;
        drive0(0, 0, 2'b00, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        if1.RegWriteE = 0; if1.MemWriteE = 0; if1.MemtoRegE = 2'b00; if1.jumpE = 0;
        if1.WriteRegE = 5'd0; if1.ALUMultOut = 32'd0; if1.WriteDataE = 32'd0; if1.PCPlus4E = 32'd0;

        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_ALUOutM",   if0.ALUOutM, 32'd0);
        chk("rst_WriteRegM", {27'd0, if0.WriteRegM}, 32'd0);
        chk("rst_RegWriteM", {31'd0, if0.RegWriteM}, 32'd0);
        chk("rst_PCPlus4M",  if0.PCPlus4M, 32'd0);
        chk("rst_busy",      {31'd0, if0.MemBusyM}, 32'd0);
        chk("rst_busy1",     {31'd0, if1.MemBusyM}, 32'd0);

        do_op0(1, 0, 2'b00, 0, 5'd5, 32'h23, 32'd0, 32'h104);

        for (int i = 0; i < 16; i++)
            do_op0(0, 1, 2'b00, 0, 5'd0, 32'(i * 4), $urandom, 32'd0);

        do_op0(0, 1, 2'b00, 0, 5'd0, 32'h10, 32'hDEAD_BEEF, 32'h200);
        do_op0(1, 0, 2'b01, 0, 5'd9, 32'h10, 32'd0, 32'h204);
        chk("lw_0x10", if0.ReadDataM, 32'hDEAD_BEEF);
        do_op0(1, 0, 2'b01, 0, 5'd9, 32'h13, 32'd0, 32'h208);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, 15);
            alu  = ($urandom & 32'hFFFF_FC00) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            mw   = 1'b0;
            case (kind)
                0:       mtr = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                1:       mtr = 2'b10;
                2:       begin mtr = 2'b00; mw = 1'b1; end
                default: mtr = 2'b01;
            endcase
            do_op0(1'($urandom), mw, mtr, 1'($urandom), 5'($urandom), alu, $urandom, $urandom);
        end

        drive0(0, 1, 2'b00, 0, 5'd0, 32'h20, 32'h1234_5678, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("abort_busy_before", {31'd0, if0.MemBusyM}, 32'd1);
        rst = 1'b1;
        drive0(0, 0, 2'b00, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        stall_exp = 0;
        chk("abort_busy",    {31'd0, if0.MemBusyM}, 32'd0);
        chk("abort_ALUOutM", if0.ALUOutM, 32'd0);
`ifdef MEM_STALL_CNT_EN
        chk("abort_StallCntM", if0.StallCntM, 32'd0);
`endif
        do_op0(1, 0, 2'b01, 0, 5'd3, 32'h20, 32'd0, 32'd0);
        do_op0(0, 1, 2'b00, 0, 5'd0, 32'h24, 32'h0BAD_CAFE, 32'd0);
        do_op0(1, 0, 2'b01, 0, 5'd4, 32'h24, 32'd0, 32'd0);
`ifdef MEM_STALL_CNT_EN
        chk("stall_three_ops", if0.StallCntM, 32'd6);
`endif
        drive0(0, 0, 2'b00, 0, 5'd0, 32'd0, 32'd0, 32'd0);

        if1.MemWriteE = 1; if1.MemtoRegE = 2'b00; if1.ALUMultOut = 32'h40; if1.WriteDataE = 32'hCAFE_F00D;
        @(posedge clk); @(negedge clk);
        chk("lat0_sw_busy", {31'd0, if1.MemBusyM}, 32'd0);
        chk("lat0_sw_addr", if1.ALUOutM, 32'h40);
        if1.MemWriteE = 0; if1.MemtoRegE = 2'b01; if1.RegWriteE = 1; if1.ALUMultOut = 32'h40;
        @(posedge clk); @(negedge clk);
        chk("lat0_lw_busy", {31'd0, if1.MemBusyM}, 32'd0);
        chk("lat0_lw_data", if1.ReadDataM, 32'hCAFE_F00D);
        if1.MemtoRegE = 2'b00; if1.RegWriteE = 0;
        @(posedge clk); @(negedge clk);
        chk("lat0_nop_busy", {31'd0, if1.MemBusyM}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the pipelined MIPS core, directly downstream of execute.
- Holds the EX/MEM pipeline register and a word-addressed data memory with configurable access latency.
- Raises a busy/stall request while a load or store is in flight, so the hazard unit freezes IF/ID/EX.
- Presents ALUOutM, ReadDataM and control fields to writeback; ALUOutM also feeds the execute forwarding muxes.

Parameters:
- MEM_WORDS, 256, data memory depth in 32-bit words (power of 2).
- MEM_LATENCY, 2, extra wait cycles per load/store (0 = single-cycle memory).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteE  in  1  register write enable from EX.
- MemWriteE  in  1  store enable from EX.
- MemtoRegE  in  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 reserved (treated as 00).
- jumpE  in  1  jump flag from EX.
- WriteRegE  in  5  destination register.
- ALUMultOut  in  32  ALU/mult result, also the memory byte address.
- WriteDataE  in  32  store data.
- PCPlus4E  in  32  link value.
- RegWriteM  out  1  registered.
- MemtoRegM  out  2  registered.
- jumpM  out  1  registered.
- WriteRegM  out  5  registered.
- ALUOutM  out  32  registered address/result.
- ReadDataM  out  32  load data, valid when MemBusyM=0.
- PCPlus4M  out  32  registered.
- MemBusyM  out  1  stall request to hazard unit.

Behaviour:
- Reset (sync, rst=1 at posedge): all M outputs 0, wait counter 0, state IDLE, MemBusyM=0. Memory array is not cleared.
- Memory op in M: memop = MemWriteM | (MemtoRegM==01). MemWriteM is internal.
- Address: word index = ALUOutM[log2(MEM_WORDS)+1:2]. Bits [1:0] are ignored. Upper bits wrap (aliasing).
- EX/MEM register captures all E inputs at posedge when MemBusyM=0. It holds while MemBusyM=1.
- FSM IDLE -> WAIT: at capture, if the incoming op is a memop and MEM_LATENCY>0, load cnt=MEM_LATENCY and go to WAIT.
- WAIT: cnt decrements each cycle. Go to IDLE when cnt reaches 0.
- MemBusyM = (state==WAIT): combinational from registered state, so it is high in the same cycle the op appears in M.
- A memop occupies M for exactly MEM_LATENCY+1 cycles. A non-memop occupies 1 cycle.
- Store: array written at the posedge ending the op's last M cycle (MemBusyM=0). It is written exactly once, never during WAIT.
- Load: ReadDataM = array[index], combinational read. It must be sampled only when MemBusyM=0.
- Back-to-back memops: the second op is captured on the same edge the first store commits. Its WAIT starts immediately.
- Store followed by load to the same word: the load returns the new data.
- rst asserted during WAIT: the access aborts, no write occurs, and everything returns to reset values next cycle.
- MemtoRegE=11 behaves as 00 and is not a memop.

Optional Feature:
- Macro MEM_STALL_CNT_EN.
- Defined: adds output StallCntM [31:0], counting cycles with MemBusyM=1. It saturates at 0xFFFFFFFF and is cleared by rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 1 cycle -> all M outputs 0, MemBusyM=0.
- ALU pass-through: RegWriteE=1, MemtoRegE=00, ALUMultOut=0x23, WriteRegE=5 -> next cycle ALUOutM=0x23, WriteRegM=5, MemBusyM never asserts.
- Store then load (MEM_LATENCY=2): sw 0xDEADBEEF to 0x10 -> MemBusyM high exactly 2 cycles. Then lw 0x10 -> MemBusyM high 2 cycles, then ReadDataM=0xDEADBEEF. Also 0x13 reads the same word.
- Stall hold: change E inputs during WAIT -> M outputs unchanged until MemBusyM falls. New values are captured on the following edge.
- Reset mid-op: sw 0x12345678 to 0x20, assert rst in WAIT cycle 1 -> MemBusyM=0 next cycle. A later lw 0x20 returns the prior contents, not 0x12345678.
- MEM_LATENCY=0 with back-to-back sw/lw to 0x40 -> no stall cycles, and the lw returns the stored value. With MEM_STALL_CNT_EN and the default latency, 3 memops give StallCntM=6.
